// File: rtl/hawk_att_lkup_fetch.sv
// ATT lookup fetch: turns an hppa lookup into one 64B AXI read of the ATT, decodes the 64-bit entry, returns a translation.
// Latency: accept at cycle 0, arvalid at 1, rready at 2, trnsl_valid at 3 when every handshake is ready immediately.
// Backpressure: one lookup in flight; lkup_req_ready is low until trnsl_valid&&trnsl_ready, and AR/trnsl outputs hold while stalled.
module hawk_att_lkup_fetch #(
  parameter logic [47:0] ATT_START = 48'h0000_0010_0000,
  parameter logic [47:0] HPPA_BASE = 48'h0001_0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  // lookup request
  input  logic         lkup_req_valid,
  output logic         lkup_req_ready,
  input  logic [35:0]  lkup_req_hppa,
  input  logic         lkup_req_zeroBlkWr,
  // AXI read address
  output logic [47:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  // AXI read data
  input  logic [511:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  // translation response
  output logic         trnsl_valid,
  input  logic         trnsl_ready,
  output logic [47:0]  trnsl_ppa,
  output logic [3:0]   trnsl_sts,
  output logic [7:0]   trnsl_zpd_cnt,
  output logic         trnsl_zpd_update,
  output logic         trnsl_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARREQ, S_RWAIT, S_RSP} state_t;

  state_t       r_state;
  state_t       w_nxt;

  logic         r_req_rdy;
  logic         r_arvalid;
  logic         r_rready;
  logic         r_tvalid;
  logic [47:0]  r_araddr;
  logic [2:0]   r_slot;
  logic         r_zbw;
  logic [47:0]  r_ppa;
  logic [3:0]   r_sts;
  logic [7:0]   r_zc;
  logic         r_upd;
  logic         r_err;

  logic         w_req_hs;
  logic         w_ar_hs;
  logic         w_r_hs;
  logic         w_t_hs;
  logic [35:0]  w_id;
  logic [47:0]  w_addr;
  logic [8:0]   w_bit;
  logic [7:0]   w_zpd;
  logic [47:0]  w_way;
  logic [3:0]   w_sts;
  logic         w_err;
  logic [7:0]   w_zc;
  logic         w_upd;

  assign w_req_hs = lkup_req_valid && r_req_rdy;
  assign w_ar_hs  = r_arvalid && arready;
  assign w_r_hs   = rvalid && r_rready;
  assign w_t_hs   = r_tvalid && trnsl_ready;

  // Entry id = ({hppa,12'b0} - HPPA_BASE) >> 12, done in the 36-bit page domain;
  // a non-zero low 12 bits of the base borrows one page.
  assign w_id   = lkup_req_hppa - HPPA_BASE[47:12] - {35'b0, |HPPA_BASE[11:0]};
  // Eight 8-byte entries per 64-byte line.
  assign w_addr = ATT_START + (({12'b0, w_id} >> 3) << 6);

  // Entry fields picked straight out of the beat by slot; reserved bits [63:60] are never read.
  assign w_bit  = {r_slot, 6'b0};
  assign w_zpd  = rdata[w_bit +: 8];
  assign w_way  = rdata[w_bit + 9'd8 +: 48];
  assign w_sts  = rdata[w_bit + 9'd56 +: 4];
  assign w_err  = (rresp != 2'b00) || !rlast;

  // Zero-page counter update rule (increment saturates at 8'hFF).
  always_comb begin
    w_zc  = w_zpd;
    w_upd = 1'b0;
    if (r_zbw) begin
      w_zc  = (w_zpd == 8'hFF) ? 8'hFF : w_zpd + 8'd1;
      w_upd = 1'b1;
    end else if (w_zpd != 8'h00) begin
      w_zc  = 8'h00;
      w_upd = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state logic: each state leaves only on its own handshake.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_hs) w_nxt = S_ARREQ;
      S_ARREQ: if (w_ar_hs)  w_nxt = S_RWAIT;
      S_RWAIT: if (w_r_hs)   w_nxt = S_RSP;
      S_RSP:   if (w_t_hs)   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Registered outputs: handshake strobes follow the next state, payloads load on their handshake.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req_rdy <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_tvalid  <= 1'b0;
      r_araddr  <= '0;
      r_slot    <= '0;
      r_zbw     <= 1'b0;
      r_ppa     <= '0;
      r_sts     <= '0;
      r_zc      <= '0;
      r_upd     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_req_rdy <= (w_nxt == S_IDLE);
      r_arvalid <= (w_nxt == S_ARREQ);
      r_rready  <= (w_nxt == S_RWAIT);
      r_tvalid  <= (w_nxt == S_RSP);
      if (w_req_hs) begin
        r_araddr <= w_addr;
        r_slot   <= lkup_req_hppa[2:0];
        r_zbw    <= lkup_req_zeroBlkWr;
      end
      if (w_r_hs) begin
        r_err <= w_err;
        r_ppa <= w_err ? 48'h0 : w_way;
        r_sts <= w_err ? 4'h0  : w_sts;
        r_zc  <= w_err ? 8'h0  : w_zc;
        r_upd <= w_err ? 1'b0  : w_upd;
      end
    end
  end

  assign lkup_req_ready   = r_req_rdy;
  assign araddr           = r_araddr;
  assign arlen            = 8'd0;
  assign arsize           = 3'b110;
  assign arburst          = 2'b01;
  assign arvalid          = r_arvalid;
  assign rready           = r_rready;
  assign trnsl_valid      = r_tvalid;
  assign trnsl_ppa        = r_ppa;
  assign trnsl_sts        = r_sts;
  assign trnsl_zpd_cnt    = r_zc;
  assign trnsl_zpd_update = r_upd;
  assign trnsl_err        = r_err;

endmodule
